// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StData,
        StAck,
        StWaitIdle,
        StDone
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_ACK        = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers on clock and data, a glitch filter on the clock
// and a one-cycle strobe on each accepted falling edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_raw,
    input  logic dat_raw,
    output logic clk_filt,
    output logic dat_sync,
    output logic clk_fall
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [CW-1:0] cnt_q;
    logic          filt_q;
    logic          fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            cnt_q      <= '0;
            filt_q     <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], clk_raw};
            dat_sync_q <= {dat_sync_q[0], dat_raw};
            fall_q     <= 1'b0;
            // Any sample that agrees with the accepted level restarts the run.
            if (clk_sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= clk_sync_q[1];
                cnt_q  <= '0;
                fall_q <= filt_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign clk_filt = filt_q;
    assign dat_sync = dat_sync_q[1];
    assign clk_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the clock, requests to send, shifts the
// frame out on device clock falls, checks the device ACK and reports done/error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = 2400,
    parameter int unsigned TIMEOUT_CYC = 360000,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2clk_in,
    input  logic       ps2dat_in,
    output logic       ps2clk_oe,
    output logic       ps2dat_oe
);

    localparam int unsigned IW = $clog2(INHIBIT_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    ps2_tx_state_e state;
    logic [9:0]    shift;
    logic [3:0]    bitcnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          ack_ok;
    logic          clk_filt;
    logic          dat_sync;
    logic          fall;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_raw  (ps2clk_in),
        .dat_raw  (ps2dat_in),
        .clk_filt (clk_filt),
        .dat_sync (dat_sync),
        .clk_fall (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            shift     <= '0;
            bitcnt    <= '0;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            ack_ok    <= 1'b0;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b0;
            tx_error  <= 1'b0;
            busy      <= 1'b0;
            ps2clk_oe <= 1'b0;
            ps2dat_oe <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            // Timeout takes priority over any fall arriving on the terminal count.
            if ((state inside {StReq, StData, StAck, StWaitIdle}) &&
                (to_cnt == TW'(TIMEOUT_CYC - 1))) begin
                ps2clk_oe <= 1'b0;
                ps2dat_oe <= 1'b0;
                ack_ok    <= 1'b0;
                tx_done   <= 1'b1;
                tx_error  <= 1'b1;
                state     <= StDone;
            end else begin
                if (state inside {StReq, StData, StAck, StWaitIdle}) begin
                    to_cnt <= to_cnt + 1'b1;
                end
                unique case (state)
                    StIdle: begin
                        if (tx_valid) begin
                            shift     <= {1'b1, odd_parity(tx_data), tx_data};
                            bitcnt    <= '0;
                            inh_cnt   <= '0;
                            to_cnt    <= '0;
                            ack_ok    <= 1'b0;
                            ps2clk_oe <= 1'b1;
                            tx_ready  <= 1'b0;
                            busy      <= 1'b1;
                            state     <= StInhibit;
                        end
                    end
                    StInhibit: begin
                        if (inh_cnt == IW'(INHIBIT_CYC - 1)) begin
                            ps2dat_oe <= 1'b1;
                            to_cnt    <= '0;
                            state     <= StReq;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end
                    StReq: begin
                        if (to_cnt == '0) begin
                            ps2clk_oe <= 1'b0;
                        end
                        if (to_cnt == TW'(1)) begin
                            state <= StData;
                        end
                    end
                    StData: begin
                        if (fall) begin
                            ps2dat_oe <= ~shift[0];
                            shift     <= {1'b1, shift[9:1]};
                            bitcnt    <= bitcnt + 1'b1;
                            if (bitcnt == 4'd9) begin
                                state <= StAck;
                            end
                        end
                    end
                    StAck: begin
                        ps2dat_oe <= 1'b0;
                        if (fall) begin
                            ack_ok <= ~dat_sync;
                            state  <= StWaitIdle;
                        end
                    end
                    StWaitIdle: begin
                        if (clk_filt && dat_sync) begin
                            tx_done  <= 1'b1;
                            tx_error <= ~ack_ok;
                            state    <= StDone;
                        end
                    end
                    StDone: begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
